// File: rtl/sdram_port_sched.sv
// Four-port round-robin burst scheduler feeding the SDRAM command engine.
// Picks one eligible FIFO port, issues a burst command and advances that port's frame address.
module sdram_port_sched #(
  parameter int ADDR_W     = 24,
  parameter int USE_W      = 10,
  parameter int FIFO_DEPTH = 512,
  parameter int WR_LEN     = 256,
  parameter int RD_LEN     = 128,
  parameter int P0_BASE    = 0,
  parameter int P0_MAX     = 307200,
  parameter int P1_BASE    = 307200,
  parameter int P1_MAX     = 614400,
  parameter int P2_BASE    = 0,
  parameter int P2_MAX     = 307200,
  parameter int P3_BASE    = 307200,
  parameter int P3_MAX     = 614400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [2*USE_W-1:0] wr_use,
  input  logic [2*USE_W-1:0] rd_use,
  input  logic [3:0]        load,
  output logic              cmd_req,
  output logic [1:0]        cmd_port,
  output logic              cmd_rw,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [8:0]        cmd_len,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [USE_W:0] WR_TH = (USE_W+1)'(WR_LEN);
  localparam logic [USE_W:0] RD_TH = (USE_W+1)'(FIFO_DEPTH - RD_LEN);

  function automatic logic [ADDR_W-1:0] f_base(input logic [1:0] p);
    case (p)
      2'd0:    f_base = ADDR_W'(P0_BASE);
      2'd1:    f_base = ADDR_W'(P1_BASE);
      2'd2:    f_base = ADDR_W'(P2_BASE);
      default: f_base = ADDR_W'(P3_BASE);
    endcase
  endfunction

  function automatic logic [ADDR_W:0] f_max(input logic [1:0] p);
    case (p)
      2'd0:    f_max = (ADDR_W+1)'(P0_MAX);
      2'd1:    f_max = (ADDR_W+1)'(P1_MAX);
      2'd2:    f_max = (ADDR_W+1)'(P2_MAX);
      default: f_max = (ADDR_W+1)'(P3_MAX);
    endcase
  endfunction

  state_t            r_state;
  logic              r_cmd_req;
  logic [1:0]        r_cmd_port;
  logic              r_cmd_rw;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [8:0]        r_cmd_len;
  logic              r_busy;
  logic [1:0]        r_rr_ptr;
  logic [ADDR_W-1:0] r_addr [4];

  logic [3:0]        w_elig;
  logic              w_found;
  logic [1:0]        w_pick;
  logic [ADDR_W:0]   w_nxt;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic              w_done_evt;

  assign w_elig[0] = init_done && ({1'b0, wr_use[USE_W-1:0]}       >= WR_TH);
  assign w_elig[1] = init_done && ({1'b0, wr_use[2*USE_W-1:USE_W]} >= WR_TH);
  assign w_elig[2] = init_done && ({1'b0, rd_use[USE_W-1:0]}       <= RD_TH);
  assign w_elig[3] = init_done && ({1'b0, rd_use[2*USE_W-1:USE_W]} <= RD_TH);

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (w_elig[r_rr_ptr + 2'(k)]) begin
        w_found = 1'b1;
        w_pick  = r_rr_ptr + 2'(k);
      end
    end
  end

  // One extra bit keeps the end-of-frame compare free of overflow.
  assign w_nxt      = {1'b0, r_addr[r_cmd_port]} + (ADDR_W+1)'(r_cmd_len);
  assign w_nxt_addr = (w_nxt >= f_max(r_cmd_port)) ? f_base(r_cmd_port) : w_nxt[ADDR_W-1:0];
  assign w_done_evt = cmd_done && ((r_state == S_WAIT) || ((r_state == S_REQ) && cmd_ack));

  // Handshake: cmd_req is a valid that stays high with every cmd_* field frozen
  // until cmd_ack (ready) is sampled high; that edge is the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cmd_req  <= 1'b0;
      r_cmd_port <= 2'd0;
      r_cmd_rw   <= 1'b0;
      r_cmd_addr <= '0;
      r_cmd_len  <= 9'd0;
      r_busy     <= 1'b0;
      r_rr_ptr   <= 2'd0;
      for (int i = 0; i < 4; i++) r_addr[i] <= f_base(2'(i));
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_cmd_port <= w_pick;
            r_cmd_rw   <= w_pick[1];
            r_cmd_addr <= r_addr[w_pick];
            r_cmd_len  <= w_pick[1] ? 9'(RD_LEN) : 9'(WR_LEN);
            r_cmd_req  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (cmd_ack) begin
            r_cmd_req <= 1'b0;
            if (cmd_done) begin
              r_busy   <= 1'b0;
              r_rr_ptr <= r_cmd_port + 2'd1;
              r_state  <= S_IDLE;
            end else begin
              r_state  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cmd_done) begin
            r_busy   <= 1'b0;
            r_rr_ptr <= r_cmd_port + 2'd1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_done_evt) r_addr[r_cmd_port] <= w_nxt_addr;
      // Reload is applied last so it overrides a coincident burst advance.
      for (int i = 0; i < 4; i++) begin
        if (load[i]) r_addr[i] <= f_base(2'(i));
      end
    end
  end

  assign cmd_req   = r_cmd_req;
  assign cmd_port  = r_cmd_port;
  assign cmd_rw    = r_cmd_rw;
  assign cmd_addr  = r_cmd_addr;
  assign cmd_len   = r_cmd_len;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sdram_port_sched.sv
// Directed bench for sdram_port_sched: a step table for single-cycle behaviour
// plus hand sequences for reset mid-burst, round-robin from reset and frame wrap.
module tb_sdram_port_sched;

  localparam int ADDR_W = 24;
  localparam int USE_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_done;
  logic [2*USE_W-1:0] wr_use;
  logic [2*USE_W-1:0] rd_use;
  logic [3:0]        load;
  logic              cmd_req;
  logic [1:0]        cmd_port;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [8:0]        cmd_len;
  logic              cmd_ack;
  logic              cmd_done;
  logic              busy;
  logic [1:0]        dbg_state;

  sdram_port_sched dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wr_use(wr_use), .rd_use(rd_use), .load(load),
    .cmd_req(cmd_req), .cmd_port(cmd_port), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_ack(cmd_ack), .cmd_done(cmd_done),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       idn;
    int         wu0, wu1, ru2, ru3;
    logic [3:0] ld;
    logic       ack, done;
    logic       e_req, e_busy;
    int         e_port, e_addr;
  } vec_t;

  vec_t vecs[$];
  logic [ADDR_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic cur_idn;
  int   cur_wu0, cur_wu1, cur_ru2, cur_ru3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input logic [3:0] ld, input logic ack, input logic done,
                     input logic e_req, input logic e_busy, input int e_port, input int e_addr);
    vec_t v;
    v.idn = cur_idn; v.wu0 = cur_wu0; v.wu1 = cur_wu1; v.ru2 = cur_ru2; v.ru3 = cur_ru3;
    v.ld = ld; v.ack = ack; v.done = done;
    v.e_req = e_req; v.e_busy = e_busy; v.e_port = e_port; v.e_addr = e_addr;
    vecs.push_back(v);
  endtask

  task automatic add_burst(input int port, input int addr, input logic [3:0] ld_ack, input logic [3:0] ld_done);
    add(4'd0,    1'b0, 1'b0, 1'b1, 1'b1, port, addr);
    add(ld_ack,  1'b1, 1'b0, 1'b0, 1'b1, port, addr);
    add(ld_done, 1'b0, 1'b1, 1'b0, 1'b0, port, addr);
  endtask

  task automatic check_fields(input string tag, input int port, input int addr);
    check({tag, "_port"}, 32'(cmd_port), 32'(port));
    check({tag, "_rw"},   32'(cmd_rw),   (port >= 2) ? 32'd1 : 32'd0);
    check({tag, "_addr"}, 32'(cmd_addr), 32'(addr));
    check({tag, "_len"},  32'(cmd_len),  (port >= 2) ? 32'd128 : 32'd256);
  endtask

  // Waits (bounded) for a grant, compares it against the scoreboard, then acks and completes it.
  task automatic do_burst(input int port);
    int t;
    logic [ADDR_W-1:0] ea;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!cmd_req && t < 16);
    ea = exp_q.pop_front();
    if (!cmd_req) begin
      check("grant_timeout", 32'(cmd_req), 32'd1);
    end else begin
      check_fields("burst", port, int'(ea));
      cmd_ack = 1'b1;
      @(posedge clk); #1;
      cmd_ack = 1'b0;
      check("burst_req_drop", 32'(cmd_req), 32'd0);
      cmd_done = 1'b1;
      @(posedge clk); #1;
      cmd_done = 1'b0;
      check("burst_busy_clr", 32'(busy), 32'd0);
    end
  endtask

  task automatic set_in(input logic idn, input int wu0, input int wu1, input int ru2, input int ru3);
    init_done = idn;
    wr_use = {USE_W'(wu1), USE_W'(wu0)};
    rd_use = {USE_W'(ru3), USE_W'(ru2)};
  endtask

  initial begin
    rst = 1'b1; load = 4'd0; cmd_ack = 1'b0; cmd_done = 1'b0;
    set_in(1'b1, 512, 512, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   32'(cmd_req),   32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_port",  32'(cmd_port),  32'd0);
    check("rst_rw",    32'(cmd_rw),    32'd0);
    check("rst_addr",  32'(cmd_addr),  32'd0);
    check("rst_len",   32'(cmd_len),   32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    cur_idn = 1'b1; cur_wu0 = 256; cur_wu1 = 0; cur_ru2 = 500; cur_ru3 = 500;
    add(4'd0, 0, 0, 1, 1, 0, 0);
    cur_wu0 = 0;   add(4'd0, 0, 0, 1, 1, 0, 0);
                   add(4'd0, 1, 0, 0, 1, 0, 0);
    cur_wu0 = 256; add(4'd0, 0, 1, 0, 0, 0, 0);
                   add(4'd0, 0, 0, 1, 1, 0, 256);
                   add(4'd0, 1, 1, 0, 0, 0, 256);
    cur_wu0 = 0;   add(4'd0, 1, 1, 0, 0, 0, 0);
    cur_wu0 = 256; add(4'd0, 0, 0, 1, 1, 0, 512);
    cur_wu0 = 0;   add(4'd0, 1, 0, 0, 1, 0, 512);
                   add(4'd0, 0, 1, 0, 0, 0, 0);
    cur_ru2 = 385; add(4'd0, 0, 0, 0, 0, 0, 0);
    cur_ru2 = 384; add(4'd0, 0, 0, 1, 1, 2, 0);
    cur_ru2 = 500; add(4'd0, 1, 0, 0, 1, 2, 0);
                   add(4'd0, 0, 1, 0, 0, 0, 0);
    cur_wu0 = 256; cur_wu1 = 256; cur_ru2 = 0; cur_ru3 = 0;
    add_burst(3, 307200, 4'd0,    4'd0);
    add_burst(0, 768,    4'd0,    4'd0);
    add_burst(1, 307200, 4'd0,    4'b0010);
    add_burst(2, 128,    4'd0,    4'd0);
    add_burst(3, 307328, 4'b0100, 4'd0);
    add_burst(0, 1024,   4'd0,    4'd0);
    add_burst(1, 307200, 4'd0,    4'd0);
    add_burst(2, 0,      4'd0,    4'd0);
    cur_idn = 1'b0;
    add(4'd0, 0, 0, 0, 0, 0, 0);
    add(4'd0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].idn, vecs[i].wu0, vecs[i].wu1, vecs[i].ru2, vecs[i].ru3);
      load = vecs[i].ld; cmd_ack = vecs[i].ack; cmd_done = vecs[i].done;
      @(posedge clk); #1;
      check($sformatf("v%0d_req", i),  32'(cmd_req), 32'(vecs[i].e_req));
      check($sformatf("v%0d_busy", i), 32'(busy),    32'(vecs[i].e_busy));
      if (vecs[i].e_req || vecs[i].e_busy)
        check_fields($sformatf("v%0d", i), vecs[i].e_port, vecs[i].e_addr);
    end
    load = 4'd0; cmd_ack = 1'b0; cmd_done = 1'b0;

    // Reset while a port-1 burst is in WAIT.
    set_in(1'b1, 0, 256, 500, 500);
    exp_q.push_back(24'd307456);
    begin
      int t;
      logic [ADDR_W-1:0] ea;
      t = 0;
      do begin
        @(posedge clk); #1;
        t++;
      end while (!cmd_req && t < 16);
      ea = exp_q.pop_front();
      check("rstw_grant", 32'(cmd_req), 32'd1);
      check_fields("rstw", 1, int'(ea));
    end
    cmd_ack = 1'b1;
    @(posedge clk); #1;
    cmd_ack = 1'b0;
    check("rstw_state_wait", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstw_req",   32'(cmd_req),   32'd0);
    check("rstw_busy",  32'(busy),      32'd0);
    check("rstw_addr",  32'(cmd_addr),  32'd0);
    check("rstw_state", 32'(dbg_state), 32'd0);

    // Round-robin from reset: every address back at its base.
    set_in(1'b1, 256, 256, 0, 0);
    exp_q.push_back(24'd0);      exp_q.push_back(24'd307200);
    exp_q.push_back(24'd0);      exp_q.push_back(24'd307200);
    exp_q.push_back(24'd256);
    do_burst(0); do_burst(1); do_burst(2); do_burst(3); do_burst(0);

    // Frame wrap on port 0: 1200 bursts exactly fill the frame.
    rst = 1'b1;
    set_in(1'b1, 256, 0, 500, 500);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 1200; k++) exp_q.push_back(ADDR_W'(k * 256));
    exp_q.push_back(24'd0);
    for (int k = 0; k < 1201; k++) do_burst(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_port_sched.md
Name: sdram_port_sched

Overview:
- Four-port burst scheduler in front of the SDRAM command engine: two write FIFOs (gray-frame buffer, marked-image buffer) and two read FIFOs (gray-frame readback, VGA readback).
- Monitors FIFO fill levels, picks one eligible port by round-robin, and issues one burst command with address and length.
- Owns the per-port frame address counters, including wrap and reload.
- Sits in the SDRAM controller clock domain (100 MHz), between the port FIFOs and the command/refresh engine.

Parameters:
- ADDR_W, 24, SDRAM word-address width.
- USE_W, 10, FIFO fill-count width.
- FIFO_DEPTH, 512, depth of every port FIFO (words).
- WR_LEN, 256, write burst length (words).
- RD_LEN, 128, read burst length (words).
- P0_BASE, 0, write port 1 frame base. P0_MAX, 307200, write port 1 end (exclusive).
- P1_BASE, 307200, write port 2 base. P1_MAX, 614400, write port 2 end.
- P2_BASE, 0, read port 1 base. P2_MAX, 307200, read port 1 end.
- P3_BASE, 307200, read port 2 base. P3_MAX, 614400, read port 2 end.

Ports:
- clk  in  1  controller clock.
- rst  in  1  synchronous active-high reset.
- init_done  in  1  SDRAM init complete; no grant while low.
- wr_use  in  2*USE_W  fill counts of write FIFOs {p1,p0}.
- rd_use  in  2*USE_W  fill counts of read FIFOs {p3,p2}.
- load  in  4  per-port pulse: reload that port's address to its BASE.
- cmd_req  out  1  burst command valid.
- cmd_port  out  2  granted port 0..3.
- cmd_rw  out  1  1 = read (ports 2,3), 0 = write.
- cmd_addr  out  ADDR_W  burst start address.
- cmd_len  out  9  burst length.
- cmd_ack  in  1  engine accepted the command.
- cmd_done  in  1  burst finished (last data beat transferred).
- busy  out  1  high from grant through the cmd_done cycle.

Behaviour:
- Clocking: all state updates on the rising edge of clk; rst is sampled synchronously.
- Reset values: state IDLE, cmd_req 0, cmd_port 0, cmd_rw 0, cmd_addr 0, cmd_len 0, busy 0, rr_ptr 0, addr[i] = Pi_BASE.
- Eligibility:
  - Write port p (0,1): wr_use[p] >= WR_LEN.
  - Read port p (2,3): rd_use[p] <= FIFO_DEPTH - RD_LEN.
  - No port is eligible while init_done = 0.
- Round-robin: search eligible ports starting at rr_ptr and wrapping 3->0; take the first hit. After each cmd_done, rr_ptr = granted+1 (mod 4).
- IDLE:
  - If any port is eligible, on the next edge latch cmd_port, cmd_rw, cmd_addr = addr[port], cmd_len = WR_LEN or RD_LEN; assert cmd_req and busy; go to REQ.
  - Latency from eligibility to cmd_req is 1 cycle.
- REQ:
  - Hold cmd_req and all cmd_* stable until cmd_ack is sampled high.
  - On that edge, drop cmd_req and go to WAIT.
  - If cmd_ack and cmd_done are both high in the same cycle, treat it as ack followed by done, i.e. apply the WAIT done-actions directly.
- WAIT:
  - On cmd_done: nxt = addr[port] + cmd_len.
  - If nxt >= Pi_MAX, addr[port] = Pi_BASE; else addr[port] = nxt.
  - Then busy = 0, go to IDLE. There is no back-to-back grant in the done cycle; the next grant comes at the earliest 1 cycle later.
- load handling:
  - load[i] in any state sets addr[i] = Pi_BASE on that edge.
  - If load[i] coincides with cmd_done for granted port i, load wins: address becomes BASE and is not incremented.
  - A burst already issued is never aborted by load.
- cmd_done or cmd_ack seen in IDLE: ignored.
- Fill counts change while in REQ/WAIT: no effect on the latched command.
- Address arithmetic: done in ADDR_W+1 bits so the compare against Pi_MAX cannot overflow.
- rst mid-burst: everything returns to reset values on that edge. The engine is reset by the same rst.

Test Plan:
- Single write: init_done=1, wr_use[p0]=256, others idle -> cmd_req 1 cycle later with port 0, rw 0, addr 0, len 256. After ack and done, addr[0]=256 and next p0 grant is at addr 256.
- Round-robin: all four eligible continuously, ack/done after 3 cycles -> grant order 0,1,2,3,0. Read grants have len 128, with P2 starting at addr 0 and P3 at 307200.
- Wrap: drive 1200 p0 bursts (1200*256 = 307200) -> the 1200th burst is at addr 306944, and the next is at addr 0.
- Read threshold: rd_use[p2]=385 -> not eligible. rd_use[p2]=384 -> granted with addr 0, len 128.
- Load collision: load[1] pulsed in the same cycle as cmd_done for port 1 at addr 307456 -> addr[1]=307200, not 307712.
- init_done low / reset: init_done=0 with all ports eligible -> cmd_req stays 0. rst asserted in WAIT -> next cycle busy=0, cmd_req=0, all addresses back to BASE.
